// File: rtl/calendar_counter.sv
// BCD calendar/clock: advances one second per qualified tick with full
// date carry (leap years included) and accepts validated parallel loads.
module calendar_counter #(
  parameter logic [15:0] RESET_YEAR  = 16'h2025,
  parameter logic [7:0]  RESET_MONTH = 8'h05,
  parameter logic [7:0]  RESET_DAY   = 8'h01
) (
  input  logic        sys_clk_in,
  input  logic        reset,
  input  logic        tick,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] set_year,
  input  logic [7:0]  set_month,
  input  logic [7:0]  set_day,
  input  logic [7:0]  set_hour,
  input  logic [7:0]  set_minute,
  input  logic [7:0]  set_second,
  output logic [15:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  second,
  output logic        day_pulse,
  output logic        load_err
);

  logic [15:0] year_reg, year_next;
  logic [7:0]  month_reg, month_next;
  logic [7:0]  day_reg, day_next;
  logic [7:0]  hour_reg, hour_next;
  logic [7:0]  minute_reg, minute_next;
  logic [7:0]  second_reg, second_next;
  logic        day_pulse_reg, day_pulse_next;
  logic        load_err_reg, load_err_next;

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc2 = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc2 = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    bcd_inc4 = r;
  endfunction

  // Decimal divisibility by 4 from digits: even tens need ones 0/4/8, odd tens need 2/6.
  function automatic logic bcd_div4(input logic [7:0] v);
    if (v[4]) bcd_div4 = (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    else      bcd_div4 = (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  function automatic logic is_leap(input logic [15:0] y);
    if (y[7:0] == 8'h00) is_leap = bcd_div4(y[15:8]);
    else                 is_leap = bcd_div4(y[7:0]);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
    case (m)
      8'h02:                      days_in_month = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: days_in_month = 8'h30;
      default:                    days_in_month = 8'h31;
    endcase
  endfunction

  logic [55:0] set_all;
  logic [13:0] digit_ok;
  logic        load_ok;
  logic [7:0]  set_dim;
  logic [7:0]  cur_dim;
  logic        advance;
  logic        sec_wrap, min_wrap, hour_wrap;

  assign set_all = {set_year, set_month, set_day, set_hour, set_minute, set_second};

  generate
    for (genvar gi = 0; gi < 14; gi++) begin : g_digit_chk
      assign digit_ok[gi] = (set_all[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  // Range compares on raw bytes are valid once every digit is known to be BCD.
  assign set_dim = days_in_month(set_month, is_leap(set_year));
  assign load_ok = (&digit_ok)
                 && (set_month >= 8'h01) && (set_month <= 8'h12)
                 && (set_day >= 8'h01) && (set_day <= set_dim)
                 && (set_hour <= 8'h23)
                 && (set_minute <= 8'h59)
                 && (set_second <= 8'h59);

  assign cur_dim   = days_in_month(month_reg, is_leap(year_reg));
  assign advance   = tick && run && !load;
  assign sec_wrap  = (second_reg == 8'h59);
  assign min_wrap  = (minute_reg == 8'h59);
  assign hour_wrap = (hour_reg == 8'h23);

  always_comb begin
    year_next      = year_reg;
    month_next     = month_reg;
    day_next       = day_reg;
    hour_next      = hour_reg;
    minute_next    = minute_reg;
    second_next    = second_reg;
    day_pulse_next = 1'b0;
    load_err_next  = 1'b0;
    if (load) begin
      if (load_ok) begin
        year_next   = set_year;
        month_next  = set_month;
        day_next    = set_day;
        hour_next   = set_hour;
        minute_next = set_minute;
        second_next = set_second;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (advance) begin
      second_next = sec_wrap ? 8'h00 : bcd_inc2(second_reg);
      if (sec_wrap) begin
        minute_next = min_wrap ? 8'h00 : bcd_inc2(minute_reg);
        if (min_wrap) begin
          hour_next = hour_wrap ? 8'h00 : bcd_inc2(hour_reg);
          if (hour_wrap) begin
            day_pulse_next = 1'b1;
            if (day_reg == cur_dim) begin
              day_next = 8'h01;
              if (month_reg == 8'h12) begin
                month_next = 8'h01;
                year_next  = bcd_inc4(year_reg);
              end else begin
                month_next = bcd_inc2(month_reg);
              end
            end else begin
              day_next = bcd_inc2(day_reg);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      year_reg      <= RESET_YEAR;
      month_reg     <= RESET_MONTH;
      day_reg       <= RESET_DAY;
      hour_reg      <= 8'h00;
      minute_reg    <= 8'h00;
      second_reg    <= 8'h00;
      day_pulse_reg <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      year_reg      <= year_next;
      month_reg     <= month_next;
      day_reg       <= day_next;
      hour_reg      <= hour_next;
      minute_reg    <= minute_next;
      second_reg    <= second_next;
      day_pulse_reg <= day_pulse_next;
      load_err_reg  <= load_err_next;
    end
  end

  assign year      = year_reg;
  assign month     = month_reg;
  assign day       = day_reg;
  assign hour      = hour_reg;
  assign minute    = minute_reg;
  assign second    = second_reg;
  assign day_pulse = day_pulse_reg;
  assign load_err  = load_err_reg;

endmodule

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 Parameter RESET_YEAR, default 16'h2025, sets the BCD year loaded on reset.
REQ-002 Parameter RESET_MONTH, default 8'h05, sets the BCD month loaded on reset.
REQ-003 Parameter RESET_DAY, default 8'h01, sets the BCD day loaded on reset.
REQ-004 sys_clk_in  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  is a synchronous, active-high reset.
REQ-006 tick  input  1  is a one-cycle advance strobe (1 Hz or accelerated rate), sampled each edge.
REQ-007 run  input  1  enables advancing; when 0, tick SHALL be ignored.
REQ-008 load  input  1  is a one-cycle request to load set_* values.
REQ-009 set_year 16, set_month 8, set_day 8, set_hour 8, set_minute 8, set_second 8 are BCD inputs, two digits per byte (set_year four digits).
REQ-010 year 16, month 8, day 8, hour 8, minute 8, second 8 are registered BCD outputs.
REQ-011 day_pulse  output  1  goes high for one cycle when the day field advances.
REQ-012 load_err  output  1  goes high for one cycle when a load is rejected.

Function
REQ-013 Advance condition: tick=1 and run=1 and load=0 at a rising edge; outputs show the new value in the following cycle (1-cycle latency).
REQ-014 Each advance SHALL add one second with BCD digit carry: second 00-59, minute 00-59, hour 00-23.
REQ-015 At the 23:59:59 carry, the day SHALL increment; if day equals days-in-month, the day SHALL go to 01 and the month SHALL increment.
REQ-016 Days-in-month: 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11; 29 for 02 in a leap year, else 28.
REQ-017 Leap year: last two digits divisible by 4 and not 00, or last two digits 00 and first two digits divisible by 4; the computation is done on BCD digits with no binary conversion.
REQ-018 When month 12 carries, month SHALL go to 01 and year SHALL increment in BCD; year 9999 SHALL wrap to 0000.
REQ-019 day_pulse SHALL assert in the same cycle the outputs show the new day (including month and year rollover).
REQ-020 Load has priority over tick; a tick in the same cycle as load SHALL be discarded.
REQ-021 A load is valid only if all of the following hold: every BCD digit is at most 9; month is 01-12; day is 01 through days-in-month for set_month/set_year; hour is at most 23; minute and second are at most 59.
REQ-022 A valid load SHALL replace all fields in the next cycle, with day_pulse=0.
REQ-023 An invalid load SHALL leave all fields unchanged and pulse load_err for one cycle.
REQ-024 The outputs SHALL never hold a non-BCD digit or an invalid date/time.
REQ-025 In a cycle with no advance and no load, all outputs SHALL hold their values; day_pulse=0 and load_err=0.

Reset
REQ-026 When reset=1 at an edge, year=RESET_YEAR, month=RESET_MONTH, day=RESET_DAY, hour=minute=second=8'h00, day_pulse=0, load_err=0.
REQ-027 Reset SHALL override load and tick in the same cycle, including a load or tick issued in the middle of a carry chain.
REQ-028 Advancing SHALL resume on the first tick after reset deasserts.

Verification
REQ-029 Reset: assert reset for 2 cycles -> 2025-05-01 00:00:00, day_pulse=0, load_err=0.
REQ-030 Leap February: load 2024-02-28 23:59:59, then tick -> 2024-02-29 00:00:00, day_pulse=1; load 2023-02-28 23:59:59, then tick -> 2023-03-01 00:00:00.
REQ-031 Century rule: 1900-02-28 23:59:59 + tick -> 1900-03-01 00:00:00; 2000-02-28 23:59:59 + tick -> 2000-02-29 00:00:00.
REQ-032 Full wrap: 9999-12-31 23:59:59 + tick -> 0000-01-01 00:00:00, day_pulse=1.
REQ-033 Rejected loads:
- load 2025-04-31 12:00:00 -> load_err=1, fields unchanged;
- set_minute=8'h5A -> load_err=1, fields unchanged.
REQ-034 Priority and run gating:
- load 2025-06-15 10:20:30 with tick=1 in the same cycle -> exactly 10:20:30;
- run=0 with 5 ticks -> no change;
- reset with load in the same cycle -> reset values.
